hazard_scoreboard_ctrl: RTL and testbench

HAZARD_SCOREBOARD_CTRL -- requirements
Module: hazard_scoreboard_ctrl

---
 rtl/hazard_scoreboard_ctrl_if.sv | 31 +++
 rtl/hazard_scoreboard_ctrl.sv | 95 +++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Decode/writeback request and stall/status bundle for the register hazard scoreboard.
// The pipeline side drives the master modport and the scoreboard controller sits on the slave modport.
interface hazard_scoreboard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_reg_write;
  logic [4:0]  id_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        issue;
  logic [31:0] busy_mask;
  logic [1:0]  state;
  logic [7:0]  stall_cnt;
  logic        deadlock;
  logic        err_underflow;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_rd, wb_reg_write, wb_rd,
    input  stall_if, stall_id, stall_ex, issue, busy_mask, state, stall_cnt, deadlock, err_underflow
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_rd, wb_reg_write, wb_rd,
    output stall_if, stall_id, stall_ex, issue, busy_mask, state, stall_cnt, deadlock, err_underflow
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Register scoreboard: per-register pending-write counters with same-cycle writeback bypass.
// Handshake: the decode instruction is offered while id_valid=1 and advances (issue=1) in any cycle hazard=0.
module hazard_scoreboard_ctrl (
  input  logic                          clk,
  input  logic                          reset,
  hazard_scoreboard_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  pc_q [32];
  logic [1:0]  pc_d [32];
  logic [31:0] busy_q, busy_d;
  logic [7:0]  stall_cnt_q;
  logic        deadlock_q, err_underflow_q;

  logic        release_hit, underflow_hit, inc_hit, hazard;
  logic [1:0]  eff_rs, eff_rt, eff_rd;

  // A release only counts against a register that has something pending;
  // the effective counts let a consumer issue in its producer's writeback cycle.
  always_comb begin
    release_hit   = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (pc_q[bus.wb_rd] != 2'd0);
    underflow_hit = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (pc_q[bus.wb_rd] == 2'd0);
    eff_rs = pc_q[bus.id_rs] - ((release_hit && (bus.wb_rd == bus.id_rs)) ? 2'd1 : 2'd0);
    eff_rt = pc_q[bus.id_rt] - ((release_hit && (bus.wb_rd == bus.id_rt)) ? 2'd1 : 2'd0);
    eff_rd = pc_q[bus.id_rd] - ((release_hit && (bus.wb_rd == bus.id_rd)) ? 2'd1 : 2'd0);
    hazard = bus.id_valid &&
             ((eff_rs != 2'd0) ||
              (bus.id_uses_rt && (eff_rt != 2'd0)) ||
              (bus.id_reg_write && (bus.id_rd != 5'd0) && (eff_rd == 2'd3)));
    inc_hit = bus.id_valid && !hazard && bus.id_reg_write && (bus.id_rd != 5'd0);
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      pc_d[i] = pc_q[i];
      if (i != 0) begin
        case ({inc_hit && (bus.id_rd == 5'(i)), release_hit && (bus.wb_rd == 5'(i))})
          2'b10:   pc_d[i] = pc_q[i] + 2'd1;
          2'b01:   pc_d[i] = pc_q[i] - 2'd1;
          default: pc_d[i] = pc_q[i];
        endcase
      end else begin
        pc_d[i] = 2'd0;
      end
      busy_d[i] = (pc_d[i] != 2'd0);
    end
  end

  always_comb begin
    state_d = IDLE;
    if (!bus.id_valid) state_d = IDLE;
    else if (hazard)   state_d = STALL;
    else               state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) pc_q[i] <= 2'd0;
      busy_q          <= 32'd0;
      state_q         <= IDLE;
      stall_cnt_q     <= 8'd0;
      deadlock_q      <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) pc_q[i] <= pc_d[i];
      busy_q  <= busy_d;
      state_q <= state_d;
      if (hazard) begin
        if (stall_cnt_q != 8'd255) stall_cnt_q <= stall_cnt_q + 8'd1;
      end else begin
        stall_cnt_q <= 8'd0;
      end
      if (hazard && (stall_cnt_q == 8'd255)) deadlock_q <= 1'b1;
      if (underflow_hit) err_underflow_q <= 1'b1;
    end
  end

  assign bus.stall_if      = hazard;
  assign bus.stall_id      = hazard;
  assign bus.stall_ex      = hazard;
  assign bus.issue         = bus.id_valid && !hazard;
  assign bus.busy_mask     = busy_q;
  assign bus.state         = state_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.deadlock      = deadlock_q;
  assign bus.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Scoreboard bench for hazard_scoreboard_ctrl: directed scenarios then random traffic
// checked against a per-register pending-count reference model.
module tb_hazard_scoreboard_ctrl;

  localparam int W = 48;

  logic clk;
  logic reset;
  hazard_scoreboard_ctrl_if bus ();

  hazard_scoreboard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state (values visible after the most recent edge)
  int m_cnt [32];
  int m_state;
  int m_stall;
  bit m_dl;
  bit m_err;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic int eff(input int r, input bit wbw, input int wbrd);
    if (wbw && r != 0 && wbrd == r && m_cnt[r] > 0) return m_cnt[r] - 1;
    return m_cnt[r];
  endfunction

  // driver: apply one cycle of inputs, push the expected outputs, advance the model
  task automatic drive(input bit rst, input bit v, input int rs, input int rt, input bit urt,
                       input bit wr, input int rd, input bit wbw, input int wbrd);
    bit hz, iss;
    logic [31:0] busy;
    @(posedge clk);
    #1;
    reset            = rst;
    bus.id_valid     = v;
    bus.id_rs        = 5'(rs);
    bus.id_rt        = 5'(rt);
    bus.id_uses_rt   = urt;
    bus.id_reg_write = wr;
    bus.id_rd        = 5'(rd);
    bus.wb_reg_write = wbw;
    bus.wb_rd        = 5'(wbrd);

    hz = v && (eff(rs, wbw, wbrd) != 0 || (urt && eff(rt, wbw, wbrd) != 0) ||
               (wr && rd != 0 && eff(rd, wbw, wbrd) == 3));
    iss = v && !hz;
    for (int i = 0; i < 32; i++) busy[i] = (m_cnt[i] != 0);
    exp_q.push_back({hz, hz, hz, iss, busy, 2'(m_state), 8'(m_stall), m_dl, m_err});

    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_state = 0; m_stall = 0; m_dl = 0; m_err = 0;
    end else begin
      if (m_stall == 255 && hz) m_dl = 1;
      m_stall = hz ? ((m_stall < 255) ? m_stall + 1 : 255) : 0;
      m_state = !v ? 0 : (hz ? 2 : 1);
      if (wbw && wbrd != 0) begin
        if (m_cnt[wbrd] == 0) m_err = 1;
        else m_cnt[wbrd] = m_cnt[wbrd] - 1;
      end
      if (iss && wr && rd != 0) m_cnt[rd] = m_cnt[rd] + 1;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: compare whatever the DUT presents against the next expectation
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.issue, bus.busy_mask, bus.state,
             bus.stall_cnt, bus.deadlock, bus.err_underflow};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL outputs @%0t: got stall=%b issue=%b busy=%h state=%b cnt=%0d dl=%b uf=%b, expected stall=%b issue=%b busy=%h state=%b cnt=%0d dl=%b uf=%b",
                 $time, act[47:45], act[44], act[43:12], act[11:10], act[9:2], act[1], act[0],
                 exp[47:45], exp[44], exp[43:12], exp[11:10], exp[9:2], exp[1], exp[0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
    bus.id_reg_write = 0; bus.id_rd = 0; bus.wb_reg_write = 0; bus.wb_rd = 0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_state = 0; m_stall = 0; m_dl = 0; m_err = 0;
    repeat (2) @(posedge clk);

    // reset state
    idle();
    // write r5, busy bit next cycle, then dependent read stalls
    drive(0, 1, 0, 0, 0, 1, 5, 0, 0);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
    // writeback of r5 in the same cycle lets the reader issue
    drive(0, 1, 5, 0, 0, 0, 0, 1, 5);
    idle();
    // three writers of r7, fourth stalls, then issues alongside a release
    drive(0, 1, 0, 0, 0, 1, 7, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 7, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 7, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 7, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 7, 1, 7);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
    idle();
    // register 0 never creates a dependency; rt ignored when not a source
    drive(0, 1, 0, 0, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 6, 0, 0);
    drive(0, 1, 0, 6, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 6, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6);
    // underflow on r9 is sticky
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle();
    idle();
    // long stall on r3 saturates the counter and raises deadlock
    drive(0, 1, 0, 0, 0, 1, 3, 0, 0);
    for (int k = 0; k < 258; k++) drive(0, 1, 3, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 0, 0, 1, 4, 0, 0);
    idle();
    // reset mid-stall discards pending counts
    drive(0, 1, 0, 0, 0, 1, 4, 0, 0);
    drive(0, 1, 4, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 4, 0, 0, 0, 0, 0, 0);
    idle();

    // random traffic over a small register set to provoke dependencies
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 8),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 6), $urandom_range(0, 7),
            ($urandom_range(0, 9) < 5), $urandom_range(0, 7));
    end
    idle();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
